lut_scanner: RTL and testbench

Sequential truth-table extractor for the lab's LUT-based gate modules. On `start` it sweeps every input combination of an `IN_W`-input, 1-output combinational block and records each response into an internal table. It then streams the recovered truth table out as bytes over a valid/ready interface. The block sits beside the gate under test: `probe` drives the gate's input vector, and the gate's output returns on `resp`.

---
 rtl/lut_scanner_if.sv | 11 +
 rtl/lut_scanner.sv | 146 ++++++++++++++
 tb/tb_lut_scanner.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_scanner_if.sv
// Valid/ready stream channel that carries the recovered truth table out of lut_scanner.
interface lut_scanner_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/lut_scanner.sv
// Sweeps every input of an IN_W-input gate, records its truth table, then streams it out.
// Optional LUT_SCAN_ONES_COUNT_EN builds a population counter of the recovered table.
module lut_scanner #(
  parameter int IN_W   = 10,
  parameter int SETTLE = 2,
  parameter int OUT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [IN_W-1:0] probe_o,
  input  logic            resp_i,
  output logic [IN_W:0]   ones_count_o,
  lut_scanner_if.master   tx_if
);
  localparam int DEPTH  = 1 << IN_W;
  localparam int NWORDS = DEPTH / OUT_W;
  localparam int K_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IN_W-1:0]  PROBE_MAX = {IN_W{1'b1}};
  localparam logic [K_W-1:0]   K_LAST    = K_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, SEND} state_t;

  state_t           state_q;
  logic [DEPTH-1:0] table_q;
  logic [CNT_W-1:0] cnt_q;
  logic [K_W-1:0]   k_q;
  logic [IN_W-1:0]  probe_q;
  logic             busy_q;
  logic             done_q;
  logic             tx_valid_q;
  logic [OUT_W-1:0] tx_data_q;

  logic [K_W-1:0]   k_d;
  logic             sample;
  logic             last_hs;
  logic [OUT_W-1:0] words [NWORDS];

  // Table bit j lands on word j/OUT_W, lane j%OUT_W.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      assign words[gi] = table_q[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign k_d     = k_q + 1'b1;
  assign sample  = (state_q == SWEEP) && (cnt_q == CNT_LAST);
  assign last_hs = (state_q == SEND) && tx_valid_q && tx_if.tx_ready && (k_q == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      table_q    <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      probe_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SWEEP;
            probe_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (sample) begin
            table_q[probe_q] <= resp_i;
            cnt_q            <= '0;
            // The last probe value stays on the gate while the table streams out.
            if (probe_q == PROBE_MAX) begin
              state_q <= SEND;
              k_q     <= '0;
            end else begin
              probe_q <= probe_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SEND: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= words[k_q];
          end else if (tx_if.tx_ready) begin
            if (last_hs) begin
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              k_q       <= k_d;
              tx_data_q <= words[k_d];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LUT_SCAN_ONES_COUNT_EN
  logic [IN_W:0] ones_acc_q;
  logic [IN_W:0] ones_count_q;

  // The running count is only published when a scan completes, so aborted scans never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_acc_q   <= '0;
      ones_count_q <= '0;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        ones_acc_q <= '0;
      end else if (sample && resp_i) begin
        ones_acc_q <= ones_acc_q + 1'b1;
      end
      if (last_hs) begin
        ones_count_q <= ones_acc_q;
      end
    end
  end

  assign ones_count_o = ones_count_q;
`else
  assign ones_count_o = '0;
`endif

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign probe_o        = probe_q;
  assign tx_if.tx_data  = tx_data_q;
  assign tx_if.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_lut_scanner.sv
// Self-checking bench for lut_scanner: vector table of scans plus reset and SETTLE=3 sequences.
`timescale 1ns/1ps
module tb_lut_scanner;
  localparam int IN_W  = 10;
  localparam int OUT_W = 8;
  localparam int NW    = (1 << IN_W) / OUT_W;
  localparam int LAT2  = (1 << IN_W) * 2 + NW + 1;
  localparam int LAT3  = (1 << IN_W) * 3 + NW + 1;
`ifdef LUT_SCAN_ONES_COUNT_EN
  localparam bit ONES_EN = 1'b1;
`else
  localparam bit ONES_EN = 1'b0;
`endif

  typedef struct {
    int         fsel;
    bit         bp;
    bit         poke;
    logic [7:0] w0;
    logic [7:0] wn;
    int         lat;
    int         ones;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, busy, done, resp;
  logic [IN_W-1:0] probe;
  logic [IN_W:0]   ones;
  logic            start3, busy3, done3, resp3_a, resp3_b;
  logic [IN_W-1:0] probe3;
  logic [IN_W:0]   ones3;
  int              func_sel;

  lut_scanner_if #(.OUT_W(OUT_W)) tx_if ();
  lut_scanner_if #(.OUT_W(OUT_W)) tx3_if ();

  always #5 clk = ~clk;

  always_comb begin
    resp = 1'b0;
    case (func_sel)
      0:       resp = probe[0];
      1:       resp = |probe;
      default: resp = (probe == 10'd5);
    endcase
  end

  // Gate with a two-cycle output delay for the SETTLE=3 instance.
  always @(posedge clk) begin
    resp3_a <= (probe3 == 10'd5);
    resp3_b <= resp3_a;
  end

  lut_scanner #(.IN_W(IN_W), .SETTLE(2), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .probe_o(probe), .resp_i(resp), .ones_count_o(ones), .tx_if(tx_if)
  );

  lut_scanner #(.IN_W(IN_W), .SETTLE(3), .OUT_W(OUT_W)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .busy_o(busy3), .done_o(done3),
    .probe_o(probe3), .resp_i(resp3_b), .ones_count_o(ones3), .tx_if(tx3_if)
  );

  int              n_cmp = 0;
  int              n_bad = 0;
  int              cyc = 0;
  int              start_cyc, done_cyc, words_seen;
  bit              done_seen, mon_en;
  logic [OUT_W-1:0] exp_q[$];
  vec_t            vecs[5];
  bit              prev_stall, prev_busy, prev_done;
  logic [OUT_W-1:0] prev_data;
  logic [IN_W-1:0] prev_probe;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Stream monitor / scoreboard for the SETTLE=2 instance.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) begin
        check("stall_valid", tx_if.tx_valid, 1);
        check("stall_data", tx_if.tx_data, prev_data);
      end
      if (busy && prev_busy)
        check("probe_mono", (int'(probe) == int'(prev_probe)) || (int'(probe) == int'(prev_probe) + 1), 1);
      if (prev_done) check("done_pulse", done, 0);
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) check("extra_word", words_seen, NW - 1);
        else check($sformatf("word%0d", words_seen), tx_if.tx_data, exp_q.pop_front());
        words_seen++;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        check("busy_at_done", busy, 0);
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      prev_busy  = busy;
      prev_probe = probe;
      prev_done  = done;
    end else begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic run_scan(input vec_t v, input int idx);
    bit stalled, poked_send, poked_done;
    int stall_left;
    func_sel = v.fsel;
    exp_q.delete();
    for (int k = 0; k < NW; k++) exp_q.push_back((k == 0) ? v.w0 : v.wn);
    words_seen = 0;
    done_seen  = 1'b0;
    tx_if.tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("probe_after_start", probe, 0);
    stalled = 0; poked_send = 0; poked_done = 0; stall_left = 0;
    for (int i = 0; i < 8000 && !done_seen; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v.bp && !stalled && words_seen == 5) begin
        stalled = 1; stall_left = 10; tx_if.tx_ready = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tx_if.tx_ready = 1'b1;
      end
      if (v.poke && i == 1000) start = 1'b1;
      if (v.poke && !poked_send && words_seen == 60) begin start = 1'b1; poked_send = 1; end
      // Lands on the same edge as the final handshake, i.e. the done edge.
      if (v.poke && !poked_done && words_seen == NW - 1) begin start = 1'b1; poked_done = 1; end
    end
    start = 1'b0;
    check("done_seen", done_seen, 1);
    check("latency", done_cyc - start_cyc, v.lat);
    check("word_count", words_seen, NW);
    check("queue_left", exp_q.size(), 0);
    check("ones_count", ones, ONES_EN ? v.ones : 0);
    @(negedge clk);
    check("idle_after_done", busy, 0);
    $display("scan %0d: fsel=%0d bp=%0d poke=%0d words=%0d latency=%0d ones=%0d",
             idx, v.fsel, v.bp, v.poke, words_seen, done_cyc - start_cyc, ones);
  endtask

  task automatic reset_mid_scan();
    func_sel = 0;
    exp_q.delete();
    words_seen = 0;
    done_seen  = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4000 && probe != 10'd300; i++) @(negedge clk);
    check("reached_probe300", probe, 300);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_probe", probe, 0);
    check("arst_valid", tx_if.tx_valid, 0);
    check("arst_data", tx_if.tx_data, 0);
    check("arst_ones", ones, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_seen, 0);
    check("idle_after_rst", busy, 0);
    $display("reset at probe=300: busy=%0d probe=%0d done_seen=%0d", busy, probe, done_seen);
  endtask

  task automatic run_scan3();
    logic [OUT_W-1:0] q3[$];
    int seen, st, dc;
    bit got;
    for (int k = 0; k < NW; k++) q3.push_back((k == 0) ? 8'h20 : 8'h00);
    tx3_if.tx_ready = 1'b1;
    seen = 0; got = 0; dc = 0;
    @(posedge clk); #1;
    start3 = 1'b1;
    st = cyc + 1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int i = 0; i < 8000 && !got; i++) begin
      @(negedge clk);
      if (tx3_if.tx_valid && tx3_if.tx_ready) begin
        if (q3.size() == 0) check("s3_extra_word", seen, NW - 1);
        else check($sformatf("s3_word%0d", seen), tx3_if.tx_data, q3.pop_front());
        seen++;
      end
      if (done3) begin got = 1; dc = cyc; end
    end
    check("s3_done_seen", got, 1);
    check("s3_latency", dc - st, LAT3);
    check("s3_word_count", seen, NW);
    check("s3_ones_count", ones3, ONES_EN ? 1 : 0);
    $display("scan settle3: words=%0d latency=%0d ones=%0d", seen, dc - st, ones3);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 8'hAA, 8'hAA, LAT2,      512};
    vecs[1] = '{1, 1'b0, 1'b0, 8'hFE, 8'hFF, LAT2,      1023};
    vecs[2] = '{0, 1'b1, 1'b0, 8'hAA, 8'hAA, LAT2 + 10, 512};
    vecs[3] = '{1, 1'b0, 1'b1, 8'hFE, 8'hFF, LAT2,      1023};
    vecs[4] = '{2, 1'b1, 1'b1, 8'h20, 8'h00, LAT2 + 10, 1};

    rst = 1'b1; start = 1'b0; start3 = 1'b0; func_sel = 0; mon_en = 1'b0;
    tx_if.tx_ready = 1'b1; tx3_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_probe", probe, 0);
    check("rst_valid", tx_if.tx_valid, 0);
    check("rst_data", tx_if.tx_data, 0);
    check("rst_ones", ones, 0);
    check("rst_busy3", busy3, 0);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_scan(vecs[i], i);
    reset_mid_scan();
    run_scan(vecs[1], 5);
    run_scan3();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
